// File: rtl/ir_pkg.sv
// Shared types and timing windows for the IR frame controller.
// All widths are in quarter NEC units (one unit = 562.5 us).
package ir_pkg;

    // Width counter size and its saturation value.
    localparam int unsigned WIDTH_W = 8;

    // Default frame length in bits.
    localparam int unsigned SIGNAL_WIDTH_DEF = 32;

    // Sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StTrail
    } ir_state_e;

    // Anything shorter than this is treated as a glitch and never matches a window.
    localparam logic [WIDTH_W-1:0] MIN_VALID_QTR    = 8'd2;

    // Inclusive classification windows.
    localparam logic [WIDTH_W-1:0] LEAD_MARK_MIN    = 8'd56;
    localparam logic [WIDTH_W-1:0] LEAD_MARK_MAX    = 8'd72;
    localparam logic [WIDTH_W-1:0] DATA_SPACE_MIN   = 8'd28;
    localparam logic [WIDTH_W-1:0] DATA_SPACE_MAX   = 8'd40;
    localparam logic [WIDTH_W-1:0] REPEAT_SPACE_MIN = 8'd14;
    localparam logic [WIDTH_W-1:0] REPEAT_SPACE_MAX = 8'd22;
    localparam logic [WIDTH_W-1:0] BIT_MARK_MIN     = 8'd2;
    localparam logic [WIDTH_W-1:0] BIT_MARK_MAX     = 8'd6;
    localparam logic [WIDTH_W-1:0] ZERO_SPACE_MIN   = 8'd2;
    localparam logic [WIDTH_W-1:0] ZERO_SPACE_MAX   = 8'd6;
    localparam logic [WIDTH_W-1:0] ONE_SPACE_MIN    = 8'd8;
    localparam logic [WIDTH_W-1:0] ONE_SPACE_MAX    = 8'd16;

    // A level held this long in any active state aborts the frame.
    localparam logic [WIDTH_W-1:0] TIMEOUT_QTR      = 8'd80;

    // True when a measured width lies inside [lo, hi] and is not a glitch.
    function automatic logic in_window(input logic [WIDTH_W-1:0] width,
                                       input logic [WIDTH_W-1:0] lo,
                                       input logic [WIDTH_W-1:0] hi);
        return (width >= MIN_VALID_QTR) && (width >= lo) && (width <= hi);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Prescaled pulse-width timer: counts quarter-unit ticks since the last clear,
// saturating at the top of the width counter.
module ir_pulse_timer
    import ir_pkg::*;
#(
    parameter int unsigned QTR_CYCLES = 7031
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    output logic               o_tick,
    output logic [WIDTH_W-1:0] o_width
);

    localparam int unsigned PRESC_W = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(QTR_CYCLES - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [WIDTH_W-1:0] r_width;
    logic               w_tick;

    assign w_tick  = (r_presc == PRESC_LAST);
    assign o_tick  = w_tick;
    assign o_width = r_width;

    // Prescaler and saturating width counter. The prescaler restarts at 1 on a
    // clear so that an edge arriving exactly N quarters after the previous one
    // sees a registered width of N (the clear cycle itself counts as one).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= '0;
            r_width <= '0;
        end else if (i_clear) begin
            r_presc <= PRESC_W'(1 % QTR_CYCLES);
            r_width <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick && (r_width != '1)) begin
                r_width <= r_width + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ir_frame_controller.sv
// NEC IR frame sequencer: synchronizes the receiver line, times marks and
// spaces, and walks leader -> data bits -> trailer, publishing decoded bits,
// complete codes, repeat frames and errors as one-cycle pulses.
module ir_frame_controller
    import ir_pkg::*;
#(
    parameter int unsigned QTR_CYCLES   = 7031,
    parameter int unsigned SIGNAL_WIDTH = SIGNAL_WIDTH_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_ir_signal,
    output logic                    o_bit_strobe,
    output logic                    o_bit,
    output logic [SIGNAL_WIDTH-1:0] o_code,
    output logic                    o_code_valid,
    output logic                    o_repeat,
    output logic                    o_error,
    output logic                    o_busy
);

    localparam int unsigned CNT_W = (SIGNAL_WIDTH > 1) ? $clog2(SIGNAL_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIGNAL_WIDTH - 1);

    // Line synchronizer and edge detect; all flops idle high.
    logic r_sync1;
    logic r_sync2;
    logic r_sync_prev;
    logic w_fall;
    logic w_rise;
    logic w_edge;

    // Timer interface.
    logic               w_tick;
    logic [WIDTH_W-1:0] w_width;
    logic               w_timeout;

    // Sequencer state and datapath.
    ir_state_e              r_state;
    ir_state_e              w_state_d;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_d;
    logic [SIGNAL_WIDTH-1:0] r_shift;
    logic [SIGNAL_WIDTH-1:0] w_shift_d;
    logic [SIGNAL_WIDTH-1:0] r_code;
    logic                   r_have_code;

    // Pulse requests computed on the edge cycle, registered onto the outputs.
    logic w_strobe;
    logic w_bit;
    logic w_load;
    logic w_repeat;
    logic w_error;

    logic r_bit_strobe;
    logic r_bit;
    logic r_code_valid;
    logic r_repeat;
    logic r_error;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync1     <= i_ir_signal;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    assign w_fall = r_sync_prev & ~r_sync2;
    assign w_rise = ~r_sync_prev & r_sync2;
    assign w_edge = w_fall | w_rise;

    ir_pulse_timer #(
        .QTR_CYCLES (QTR_CYCLES)
    ) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_edge),
        .o_tick  (w_tick),
        .o_width (w_width)
    );

    // Fires on the tick that steps the width counter onto the timeout value.
    assign w_timeout = (r_state != StIdle) && w_tick && (w_width == TIMEOUT_QTR - 8'd1);

    // Next-state and pulse requests; only edge cycles and timeouts move the FSM.
    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        w_shift_d = r_shift;
        w_strobe  = 1'b0;
        w_bit     = 1'b0;
        w_load    = 1'b0;
        w_repeat  = 1'b0;
        w_error   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_fall) begin
                    w_state_d = StLeadMark;
                end
            end
            StLeadMark: begin
                if (w_rise) begin
                    if (in_window(w_width, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                        w_state_d = StLeadSpace;
                    end else begin
                        w_error   = 1'b1;
                        w_state_d = StIdle;
                    end
                end
            end
            StLeadSpace: begin
                if (w_fall) begin
                    if (in_window(w_width, DATA_SPACE_MIN, DATA_SPACE_MAX)) begin
                        w_state_d = StBitMark;
                        w_count_d = '0;
                    end else if (in_window(w_width, REPEAT_SPACE_MIN, REPEAT_SPACE_MAX)) begin
                        // A repeat is only meaningful once a code has been received.
                        w_repeat  = r_have_code;
                        w_error   = ~r_have_code;
                        w_state_d = StTrail;
                    end else begin
                        w_error   = 1'b1;
                        w_state_d = StTrail;
                    end
                end
            end
            StBitMark: begin
                if (w_rise) begin
                    if (in_window(w_width, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                        w_state_d = StBitSpace;
                    end else begin
                        w_error   = 1'b1;
                        w_state_d = StIdle;
                    end
                end
            end
            StBitSpace: begin
                if (w_fall) begin
                    if (in_window(w_width, ZERO_SPACE_MIN, ZERO_SPACE_MAX) ||
                        in_window(w_width, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                        w_strobe  = 1'b1;
                        w_bit     = in_window(w_width, ONE_SPACE_MIN, ONE_SPACE_MAX);
                        // LSB-first on the air: shifting right leaves bit 0 first.
                        w_shift_d = {w_bit, r_shift[SIGNAL_WIDTH-1:1]};
                        if (r_count == LAST_BIT) begin
                            w_load    = 1'b1;
                            w_state_d = StTrail;
                        end else begin
                            w_count_d = r_count + 1'b1;
                            w_state_d = StBitMark;
                        end
                    end else begin
                        w_error   = 1'b1;
                        w_state_d = StTrail;
                    end
                end
            end
            StTrail: begin
                if (w_rise) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Edges never coincide with a live timeout in practice; edge handling wins.
        if (!w_edge && w_timeout) begin
            w_error   = 1'b1;
            w_state_d = StIdle;
        end
    end

    // State, datapath and registered output pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_count      <= '0;
            r_shift      <= '0;
            r_code       <= '0;
            r_have_code  <= 1'b0;
            r_bit_strobe <= 1'b0;
            r_bit        <= 1'b0;
            r_code_valid <= 1'b0;
            r_repeat     <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_count      <= w_count_d;
            r_shift      <= w_shift_d;
            r_bit_strobe <= w_strobe;
            r_bit        <= w_strobe & w_bit;
            r_code_valid <= w_load;
            r_repeat     <= w_repeat;
            r_error      <= w_error;
            if (w_load) begin
                r_code      <= w_shift_d;
                r_have_code <= 1'b1;
            end
        end
    end

    assign o_bit_strobe = r_bit_strobe;
    assign o_bit        = r_bit;
    assign o_code       = r_code;
    assign o_code_valid = r_code_valid;
    assign o_repeat     = r_repeat;
    assign o_error      = r_error;
    assign o_busy       = (r_state != StIdle);

endmodule

// File: doc/ir_frame_controller.md
Name: ir_frame_controller

Overview:
- Synchronous frame sequencer for the IR remote path: samples the raw receiver line in the i_clk domain and measures mark/space widths with a prescaled counter.
- Walks a leader → 32 data bits → trailer state machine, strobing each decoded bit and latching the full 32-bit code on completion.
- Replaces edge-clocked sequencing of the bit shift register; downstream checksum validator and button decoder consume o_code/o_code_valid.

Parameters:
- QTR_CYCLES, 7031: i_clk cycles per quarter NEC unit (562.5 us / 4 at 50 MHz); min 2.
- SIGNAL_WIDTH, 32: bits per frame.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_ir_signal  in  1  raw receiver output, asynchronous; idle high, mark = low
- o_bit_strobe  out  1  one-cycle pulse per decoded data bit
- o_bit  out  1  value of decoded bit, valid with o_bit_strobe
- o_code  out  SIGNAL_WIDTH  last complete frame; first-received bit in bit 0
- o_code_valid  out  1  one-cycle pulse when o_code updates
- o_repeat  out  1  one-cycle pulse on valid repeat frame
- o_error  out  1  one-cycle pulse on any malformed/timed-out frame
- o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, o_code = 0, state IDLE, have_code flag 0, synchronizer flops set to 1 (idle line).
- Input: 2-FF synchronizer, then edge detect on synced value; fall = mark start, rise = mark end. Edge seen 3 cycles after pin change.
- Timer: prescaler emits tick every QTR_CYCLES cycles; width counter (8 bits) counts ticks, saturates at 255, cleared with prescaler on every edge.
- Classification windows (quarter-units, inclusive): LEAD_MARK 56..72; DATA_SPACE 28..40; REPEAT_SPACE 14..22; BIT_MARK 2..6; ZERO_SPACE 2..6; ONE_SPACE 8..16. Width 0..1 is always invalid.
- Timeout: width reaching 80 in any non-IDLE state → o_error, state IDLE.
- FSM, evaluated on the edge cycle:
  - IDLE: fall → LEAD_MARK.
  - LEAD_MARK: rise; width in LEAD_MARK → LEAD_SPACE, else o_error → IDLE.
  - LEAD_SPACE: fall; DATA_SPACE → BIT_MARK, bit count = 0. REPEAT_SPACE → TRAIL, with o_repeat only if have_code = 1, else o_error. Otherwise o_error → TRAIL.
  - BIT_MARK: rise; BIT_MARK width → BIT_SPACE, else o_error → IDLE.
  - BIT_SPACE: fall; ZERO_SPACE → bit 0, ONE_SPACE → bit 1, else o_error → TRAIL.
    - On valid bit: o_bit_strobe/o_bit pulse; working register shifts right with bit into MSB.
    - If count = SIGNAL_WIDTH-1: next cycle o_code ← working register, o_code_valid pulse, have_code ← 1, → TRAIL. Else count+1 → BIT_MARK.
  - TRAIL: rise → IDLE. Timeout also applies.
- Edge in unexpected polarity cannot occur; no glitch filter beyond min-width rejection.
- o_code holds its value through errors, repeats and new frames until the next full valid frame.
- i_reset mid-frame: abort immediately to reset values; a subsequent partial frame fails the leader and raises o_error.

Decomposition:
- Package ir_pkg:
  - state enum
  - window bound localparams
  - timeout constant
  - SIGNAL_WIDTH default
- Sub-module ir_pulse_timer: prescaler plus saturating width counter, with clear and tick outputs.

Test Plan:
- Frame code 0x00FF_30CF (bit0 first, NEC timing, QTR_CYCLES=4 in sim): 32 o_bit_strobe pulses, then one o_code_valid with o_code = 0x00FF30CF, o_error never high.
- Repeat after valid frame: mark 64, space 18 qtr → single o_repeat, o_code unchanged. Same repeat straight after reset → o_error, no o_repeat.
- Leader mark 40 qtr → o_error on rise, state IDLE, no strobes.
- Line held low 100 qtr after 10 bits → o_error when width hits 80, o_busy drops, o_code keeps prior value.
- Bit space 7 qtr (between windows) at bit 5 → o_error, exactly 5 strobes, o_code_valid absent.
- i_reset asserted during bit 20 → next cycle all outputs 0, o_code 0; next full frame decodes correctly.
